// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl
//  Purpose  : Valid/ready sequencing front end for the combinational ALU.
//             Accepts one command, drives the ALU inputs, holds them for a
//             settle window, captures result/carry/zero and presents them on
//             a valid/ready result port.
//  Options  : ALU_CTRL_STATS_EN adds the 16-bit op_count port and counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_codigo,
    input  logic [WIDTH-1:0] cmd_op1,
    input  logic [WIDTH-1:0] cmd_op2,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_codigo,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_zero,
    output logic             busy
`ifdef ALU_CTRL_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    // A settle window of zero still needs one cycle for the ALU to resolve.
    localparam int c_SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int c_CNT_W      = (c_SETTLE_EFF > 1) ? $clog2(c_SETTLE_EFF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_alu_op1;
    logic [WIDTH-1:0]   r_alu_op2;
    logic [2:0]         r_alu_codigo;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_cout;
    logic               r_res_zero;

    // Sequencer: accept command, count down the settle window, capture, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_codigo <= '0;
            r_res_data   <= '0;
            r_res_cout   <= 1'b0;
            r_res_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_op1    <= cmd_op1;
                        r_alu_op2    <= cmd_op2;
                        r_alu_codigo <= cmd_codigo;
                        r_cnt        <= c_CNT_LOAD;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_res_data <= alu_res;
                        r_res_cout <= alu_cout;
                        r_res_zero <= (alu_res == '0);
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CTRL_STATS_EN
    logic [15:0] r_op_count;

    // Count completed result handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 16'd0;
        end else if ((r_state == S_DONE) && res_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    // Handshake/status outputs depend on state only.
    assign cmd_ready  = (r_state == S_IDLE);
    assign res_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign alu_codigo = r_alu_codigo;
    assign res_data   = r_res_data;
    assign res_cout   = r_res_cout;
    assign res_zero   = r_res_zero;

endmodule
`default_nettype wire
